// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: sequencing controller that turns a free-running WIDTH-bit counter
// into a commandable timer. It supports start, stop and hold commands, a programmable
// terminal count, and one-shot or periodic (auto-reload) operation. All outputs are
// registered.
//
// Ports:
//   clk       system clock; all state changes on the rising edge
//   rst       asynchronous active-low reset
//   start     begin a run; sampled only in IDLE
//   stop      abort the current run; has the highest priority
//   hold      level input; freezes the count while high
//   periodic  mode select, latched when a start is accepted (1 = auto-reload)
//   tc        terminal count, latched when a start is accepted
//   a         current count
//   busy      high in RUN, PAUSE and FINISH
//   paused    high in PAUSE
//   done      one-cycle pulse per terminal-count event
//   err       sticky; set when a start is rejected because tc == 0

module counter_seq_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  input  logic             periodic,
  input  logic [WIDTH-1:0] tc,
  output logic [WIDTH-1:0] a,
  output logic             busy,
  output logic             paused,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StPause,
    StFinish
  } state_e;

  state_e           state;
  logic [WIDTH-1:0] tc_r;
  logic             mode_r;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= StIdle;
      a      <= '0;
      tc_r   <= '0;
      mode_r <= 1'b0;
      busy   <= 1'b0;
      paused <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      // done is a pulse; only the terminal-count branch raises it.
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          // start together with stop is ignored.
          if (start && !stop) begin
            if (tc != '0) begin
              state  <= StRun;
              a      <= '0;
              tc_r   <= tc;
              mode_r <= periodic;
              busy   <= 1'b1;
              err    <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end
        end

        StRun: begin
          if (stop) begin
            state <= StIdle;
            a     <= '0;
            busy  <= 1'b0;
          end else if (hold) begin
            state  <= StPause;
            paused <= 1'b1;
          end else if (a != tc_r) begin
            a <= a + 1'b1;
          end else begin
            done <= 1'b1;
            if (mode_r) begin
              a <= '0;
            end else begin
              // One-shot: a stays at tc_r through FINISH and into IDLE.
              state <= StFinish;
            end
          end
        end

        StPause: begin
          if (stop) begin
            state  <= StIdle;
            a      <= '0;
            busy   <= 1'b0;
            paused <= 1'b0;
          end else if (!hold) begin
            // Return to RUN without counting on this edge: a one-cycle resume bubble.
            state  <= StRun;
            paused <= 1'b0;
          end
        end

        StFinish: begin
          state <= StIdle;
          busy  <= 1'b0;
          if (stop) begin
            a <= '0;
          end
        end

        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule
